pkt_loader: RTL and testbench
=============================

PKT_LOADER -- requirements
Module: pkt_loader

Interface
REQ-001 Parameter RAM_WIDTH, 8, frame-buffer data width in bits.
REQ-002 Parameter RAM_ADDR_BITS, 10, frame-buffer address width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, 1024, idle-input cycles tolerated mid-frame.
REQ-004 clock  input  1  rising-edge clock; all state changes on posedge clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  incoming byte present.
REQ-007 in_data  input  RAM_WIDTH  incoming byte.
REQ-008 in_ready  output  1  loader accepts a byte this cycle; transfer when in_valid && in_ready.
REQ-009 write_enable  output  1  frame-buffer write strobe, one cycle per byte.
REQ-010 address  output  RAM_ADDR_BITS  frame-buffer write address.
REQ-011 mem_input  output  RAM_WIDTH  frame-buffer write data.
REQ-012 mem_ready  output  1  complete frame in buffer; checksum stage may start.
REQ-013 payload_len  output  16  payload byte count of the buffered frame.
REQ-014 work_complete  input  1  checksum stage finished with the buffer.
REQ-015 frame_error  output  1  one-cycle pulse on rejected or aborted frame.

Function
REQ-016 Frame format SHALL be: byte 0 = SYNC_BYTE 8'hA5; bytes 1-3 header; byte 4 = length low; byte 5 = length high; then payload_len payload bytes.
REQ-017 States SHALL be IDLE, HEADER, LEN, PAYLOAD, DONE, ERROR.
REQ-018 in_ready SHALL be 1 in IDLE, HEADER, LEN, PAYLOAD and 0 in DONE, ERROR.
REQ-019 IDLE: accepted byte != SYNC_BYTE SHALL be discarded with no write; accepted SYNC_BYTE SHALL go to HEADER and be written at address 0.
REQ-020 Every non-discarded accepted byte with index n SHALL produce, exactly one cycle later, write_enable=1, address=n, mem_input=byte.
REQ-021 HEADER SHALL accept bytes 1-3, then LEN; LEN SHALL accept bytes 4-5 and latch payload_len = {byte5, byte4} when byte 5 is accepted.
REQ-022 MAX_LEN SHALL be 2^RAM_ADDR_BITS - 8 (two addresses reserved for checksum write-back); payload_len > MAX_LEN SHALL go to ERROR after byte 5 is written.
REQ-023 payload_len == 0 SHALL go from LEN straight to DONE; otherwise PAYLOAD, leaving after byte index 5+payload_len is accepted.
REQ-024 Last byte accepted at cycle T: write at T+1, mem_ready=1 from T+2, held until work_complete sampled 1.
REQ-025 DONE with work_complete=1 SHALL return to IDLE next cycle with mem_ready=0; work_complete outside DONE SHALL be ignored.
REQ-026 Timeout: in HEADER, LEN or PAYLOAD, TIMEOUT_CYCLES consecutive cycles with in_valid=0 SHALL go to ERROR; any accepted byte clears the counter.
REQ-027 ERROR SHALL last one cycle with frame_error=1, write_enable=0, mem_ready=0, then IDLE.
REQ-028 In-frame SYNC_BYTE values SHALL be treated as ordinary data (no resync mid-frame).
REQ-029 Byte index counter SHALL be 16 bits internally; address SHALL be its low RAM_ADDR_BITS bits, never wrapping given REQ-022.

Reset
REQ-030 reset=1 SHALL in the next cycle force IDLE, in_ready=0 during reset, write_enable=0, address=0, mem_input=0, mem_ready=0, payload_len=0, frame_error=0, timeout counter=0.
REQ-031 reset mid-frame or in DONE SHALL abandon the frame with no frame_error pulse and no further writes.

Structure
REQ-032 Package pkt_pkg SHALL hold SYNC_BYTE, header offsets LEN_ADDR_LO=4 and LEN_ADDR_HI=5, HEADER_BYTES=6, and the state encoding, shared with the checksum stage.
REQ-033 Sub-module pkt_timeout SHALL implement the idle watchdog (clear, enable, expired).

Verification
REQ-034 A5 01 02 03 04 00 11 22 33 44 back-to-back -> writes addr 0-9 with those bytes, payload_len=4, mem_ready 2 cycles after 0x44 accepted.
REQ-035 00 FF A5 01 02 03 00 00 -> 00/FF not written, writes addr 0-5, payload_len=0, mem_ready; work_complete pulse -> IDLE, mem_ready=0 next cycle.
REQ-036 RAM_ADDR_BITS=10, length bytes F9 03 (1017 > 1016) -> bytes 0-5 written, frame_error pulse, no mem_ready.
REQ-037 TIMEOUT_CYCLES=16, frame stalls after byte 7 for 16 cycles -> frame_error pulse, IDLE; stall of 15 cycles then resume -> normal completion.
REQ-038 reset asserted during PAYLOAD -> all outputs at reset values next cycle, no frame_error; subsequent valid frame loads correctly from address 0.

Source files
------------

// File: rtl/pkt_pkg.sv
// pkt_pkg: constants and state encoding shared by the frame loader and the
// checksum stage that consumes the frame buffer.
//   SYNC_BYTE      first byte of every frame
//   LEN_ADDR_LO/HI buffer offsets of the little-endian payload length
//   HEADER_BYTES   bytes preceding the payload (sync + 3 header + 2 length)
//   pkt_state_e    loader state encoding
package pkt_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam int         LEN_ADDR_LO  = 4;
  localparam int         LEN_ADDR_HI  = 5;
  localparam int         HEADER_BYTES = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } pkt_state_e;

endpackage

// File: rtl/pkt_timeout.sv
// pkt_timeout: idle watchdog. Counts consecutive enabled cycles and flags
// expiry on the TIMEOUT_CYCLES-th one.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : zero the count (wins over enable)
//   enable       : this cycle counts as idle
//   expired      : this is the TIMEOUT_CYCLES-th consecutive idle cycle
module pkt_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = enable && !clear && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Saturates once expired; the owner leaves the counted states and clears.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)                  cnt_d = '0;
    else if (enable && !expired) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pkt_loader.sv
// pkt_loader: receives a byte stream, finds frames starting with SYNC_BYTE and
// writes them into the frame buffer from address 0, then hands the buffer to
// the checksum stage.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   in_valid/in_data      : byte stream in, in_ready accepts
//   write_enable/address/mem_input : registered buffer write port
//   mem_ready/payload_len : complete frame available, its payload length
//   work_complete         : checksum stage releases the buffer
//   frame_error           : one-cycle pulse on oversize or timed-out frame
module pkt_loader
  import pkt_pkg::*;
#(
  parameter int RAM_WIDTH      = 8,
  parameter int RAM_ADDR_BITS  = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [RAM_WIDTH-1:0]     in_data,
  output logic                     in_ready,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] address,
  output logic [RAM_WIDTH-1:0]     mem_input,
  output logic                     mem_ready,
  output logic [15:0]              payload_len,
  input  logic                     work_complete,
  output logic                     frame_error
);

  // Last two buffer words are kept free for the checksum write-back.
  localparam int MAX_LEN = (1 << RAM_ADDR_BITS) - 8;

  pkt_state_e               state_q, state_d;
  logic [15:0]              idx_q, idx_d;        // index of the next frame byte
  logic [7:0]               len_lo_q, len_lo_d;
  logic [15:0]              len_q, len_d;
  logic                     len_bad_q, len_bad_d;
  logic                     we_q, we_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [RAM_WIDTH-1:0]     data_q, data_d;
  logic                     mem_ready_q, mem_ready_d;
  logic                     accept, in_frame, expired;

  assign in_frame = (state_q == HEADER) || (state_q == LEN) || (state_q == PAYLOAD);
  assign accept   = in_valid && in_ready;

  pkt_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_frame || accept),
    .enable  (in_frame && !in_valid),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_lo_q    <= '0;
      len_q       <= '0;
      len_bad_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      len_bad_q   <= len_bad_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    len_bad_d   = 1'b0;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    mem_ready_d = 1'b0;

    // Every accepted in-frame byte is written one cycle later at its index.
    if (accept) begin
      we_d   = 1'b1;
      addr_d = idx_q[RAM_ADDR_BITS-1:0];
      data_d = in_data;
      idx_d  = idx_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_data[7:0] == SYNC_BYTE) begin
            state_d = HEADER;
          end else begin
            // Hunting for sync: drop the byte entirely.
            we_d   = 1'b0;
            addr_d = addr_q;
            data_d = data_q;
            idx_d  = idx_q;
          end
        end
      end
      HEADER: begin
        if (accept && idx_q == 16'(LEN_ADDR_LO - 1)) state_d = LEN;
      end
      LEN: begin
        if (len_bad_q) begin
          // Oversize length byte has just been written; now reject.
          state_d = ERROR;
        end else if (accept) begin
          if (idx_q == 16'(LEN_ADDR_LO)) begin
            len_lo_d = in_data[7:0];
          end else begin
            len_d = {in_data[7:0], len_lo_q};
            if (len_d > 16'(MAX_LEN)) len_bad_d = 1'b1;
            else if (len_d == 16'd0)  state_d   = DONE;
            else                      state_d   = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept && idx_q == 16'(HEADER_BYTES - 1) + len_q) state_d = DONE;
      end
      DONE: begin
        // mem_ready rises the cycle after entry, after the last write lands.
        if (mem_ready_q && work_complete) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          mem_ready_d = 1'b1;
        end
      end
      ERROR: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    if (expired) state_d = ERROR;
  end

  always_comb begin
    // Stall the stream during reset and for the cycle between an oversize
    // length being written and the frame being rejected.
    in_ready    = !reset && !len_bad_q && (in_frame || state_q == IDLE);
    frame_error = (state_q == ERROR);
  end

  assign write_enable = we_q;
  assign address      = addr_q;
  assign mem_input    = data_q;
  assign mem_ready    = mem_ready_q;
  assign payload_len  = len_q;

endmodule

// File: tb/tb_pkt_loader.sv
module tb_pkt_loader;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          work_complete = 1'b0;
  logic          in_ready, write_enable, mem_ready, frame_error;
  logic [AW-1:0] address;
  logic [DW-1:0] mem_input;
  logic [15:0]   payload_len;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_ferr = 0;
  int widx   = 0;
  int ferr0;
  logic [17:0] exp_q[$];
  logic [17:0] e;

  pkt_loader #(.RAM_WIDTH(DW), .RAM_ADDR_BITS(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .write_enable (write_enable),
    .address      (address),
    .mem_input    (mem_input),
    .mem_ready    (mem_ready),
    .payload_len  (payload_len),
    .work_complete(work_complete),
    .frame_error  (frame_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected one.
  always @(negedge clock) begin
    if (frame_error) n_ferr++;
    if (write_enable) begin
      chk("wr_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(address), 32'(e[17:8]));
        chk("wr_data", 32'(mem_input), 32'(e[7:0]));
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit wr);
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    if (wr) begin
      exp_q.push_back({widx[9:0], b});
      widx++;
    end
    @(posedge clock);
  endtask

  task automatic go_idle();
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] len);
    widx = 0;
    send(8'hA5, 1); send(8'h01, 1); send(8'h02, 1); send(8'h03, 1);
    send(len[7:0], 1); send(len[15:8], 1);
  endtask

  // Called right after the last byte is accepted: write lands next cycle,
  // mem_ready the cycle after.
  task automatic expect_done(input string tag, input logic [15:0] len);
    go_idle();
    chk({tag, "_mr_early"}, mem_ready, 0);
    @(negedge clock);
    chk({tag, "_mr"}, mem_ready, 1);
    chk({tag, "_len"}, payload_len, len);
    chk({tag, "_rdy_done"}, in_ready, 0);
  endtask

  task automatic release_buf(input string tag);
    @(negedge clock); work_complete = 1'b1;
    @(negedge clock); work_complete = 1'b0;
    chk({tag, "_mr_clr"}, mem_ready, 0);
    chk({tag, "_rdy_idle"}, in_ready, 1);
  endtask

  initial begin
    logic [7:0] v34[10] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] v35[6]  = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00};

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_rdy", in_ready, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_addr", 32'(address), 0);
    chk("rst_data", 32'(mem_input), 0);
    chk("rst_mr", mem_ready, 0);
    chk("rst_len", payload_len, 0);
    chk("rst_fe", frame_error, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_rdy", in_ready, 1);

    // Back-to-back frame with 4-byte payload
    widx = 0;
    foreach (v34[i]) send(v34[i], 1);
    expect_done("t34", 16'd4);
    release_buf("t34");

    // Junk before sync, zero-length payload, buffer held until released
    send(8'h00, 0); send(8'hFF, 0);
    widx = 0;
    foreach (v35[i]) send(v35[i], 1);
    expect_done("t35", 16'd0);
    repeat (3) @(negedge clock);
    chk("t35_mr_hold", mem_ready, 1);
    release_buf("t35");

    // Oversize length: 1017 > 1016
    ferr0 = n_ferr;
    send_hdr(16'h03F9);
    go_idle();
    chk("t36_we5", write_enable, 1);
    chk("t36_fe_early", frame_error, 0);
    @(negedge clock);
    chk("t36_fe", frame_error, 1);
    chk("t36_we_err", write_enable, 0);
    chk("t36_mr", mem_ready, 0);
    @(negedge clock);
    chk("t36_fe_clr", frame_error, 0);
    chk("t36_rdy_idle", in_ready, 1);
    #1;
    chk("t36_fe_cnt", 32'(n_ferr - ferr0), 1);

    // Largest legal length: 1016 payload bytes fill up to address 1021
    send_hdr(16'd1016);
    for (int i = 0; i < 1016; i++) send(8'($urandom_range(0, 255)), 1);
    expect_done("tmax", 16'd1016);
    release_buf("tmax");

    // Stall of TIMEOUT_CYCLES after byte 7 aborts the frame
    ferr0 = n_ferr;
    send_hdr(16'd3);
    send(8'h11, 1); send(8'h22, 1);
    go_idle();
    repeat (TO - 1) @(negedge clock);
    chk("t37_fe_early", frame_error, 0);
    @(negedge clock);
    chk("t37_fe", frame_error, 1);
    chk("t37_mr", mem_ready, 0);
    @(negedge clock);
    chk("t37_rdy_idle", in_ready, 1);
    #1;
    chk("t37_fe_cnt", 32'(n_ferr - ferr0), 1);

    // Stall one cycle short of the timeout, then complete normally
    ferr0 = n_ferr;
    send_hdr(16'd3);
    send(8'h11, 1); send(8'h22, 1);
    go_idle();
    repeat (TO - 2) @(negedge clock);
    send(8'h33, 1);
    expect_done("t37b", 16'd3);
    #1;
    chk("t37b_fe_cnt", 32'(n_ferr - ferr0), 0);
    release_buf("t37b");

    // Reset in PAYLOAD abandons the frame silently
    ferr0 = n_ferr;
    send_hdr(16'd4);
    send(8'h11, 1); send(8'h22, 1);
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    chk("t38_rdy", in_ready, 0);
    chk("t38_we", write_enable, 0);
    chk("t38_addr", 32'(address), 0);
    chk("t38_data", 32'(mem_input), 0);
    chk("t38_mr", mem_ready, 0);
    chk("t38_len", payload_len, 0);
    chk("t38_fe", frame_error, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("t38_rdy_idle", in_ready, 1);
    widx = 0;
    foreach (v34[i]) send(v34[i], 1);
    expect_done("t38b", 16'd4);
    release_buf("t38b");
    #1;
    chk("t38_fe_cnt", 32'(n_ferr - ferr0), 0);

    repeat (3) @(negedge clock);
    chk("sb_empty", 32'(exp_q.size()), 0);
    chk("fe_total", 32'(n_ferr), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
